// File: rtl/conv_arb_sched_pkg.sv
// Shared definitions for the two-requester pixel arbiter: FSM encoding,
// the pipeline tag layout and the pixel channel positions.
package conv_arb_sched_pkg;

   localparam int PIX_W = 24;
   localparam int CH_W  = 8;
   localparam int RES_W = 18;
   localparam int R_LSB = 16;
   localparam int G_LSB = 8;
   localparam int B_LSB = 0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GRANT0 = 2'd1,
      ST_GRANT1 = 2'd2
   } state_t;

   // Travels alongside the datapath; id/last are forced to 0 on bubbles.
   typedef struct packed {
      logic beat;
      logic id;
      logic last;
   } tag_t;

   localparam int TAG_W = $bits(tag_t);

   function automatic state_t grant_state(input logic id);
      return id ? ST_GRANT1 : ST_GRANT0;
   endfunction

   function automatic logic [CH_W-1:0] pix_ch(input logic [PIX_W-1:0] pix, input int lsb);
      return pix[lsb +: CH_W];
   endfunction

endpackage

// File: rtl/conv_arb_sched_if.sv
// Requester, kernel datapath and result signals of conv_arb_sched.
// The slave modport is the arbiter's view; master is the surrounding system.
interface conv_arb_sched_if;
   import conv_arb_sched_pkg::*;

   logic             req0_valid;
   logic [PIX_W-1:0] req0_pix;
   logic             req0_last;
   logic             req0_ready;
   logic             req1_valid;
   logic [PIX_W-1:0] req1_pix;
   logic             req1_last;
   logic             req1_ready;
   logic [CH_W-1:0]  kern_din_r;
   logic [CH_W-1:0]  kern_din_g;
   logic [CH_W-1:0]  kern_din_b;
   logic [RES_W-1:0] kern_dout;
   logic             res_valid;
   logic [RES_W-1:0] res_data;
   logic             res_id;
   logic             res_last;

   modport slave (
      input  req0_valid, req0_pix, req0_last, req1_valid, req1_pix, req1_last, kern_dout,
      output req0_ready, req1_ready, kern_din_r, kern_din_g, kern_din_b,
             res_valid, res_data, res_id, res_last
   );

   modport master (
      output req0_valid, req0_pix, req0_last, req1_valid, req1_pix, req1_last, kern_dout,
      input  req0_ready, req1_ready, kern_din_r, kern_din_g, kern_din_b,
             res_valid, res_data, res_id, res_last
   );

endinterface

// File: rtl/conv_tag_pipe.sv
// Delay line of DEPTH registers carrying the beat tag so it lines up with
// the kernel datapath output.
module conv_tag_pipe
   import conv_arb_sched_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic resetn,
   input  tag_t din,
   output tag_t dout
);

   tag_t stage_reg [DEPTH];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_reg[i] <= '0;
         end
      end else begin
         stage_reg[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            stage_reg[i] <= stage_reg[i-1];
         end
      end
   end

   assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/conv_arb_sched.sv
// Round-robin burst arbiter feeding two pixel streams into one shared kernel
// datapath; optional per-requester counters are built with CONV_ARB_STATS_EN.
module conv_arb_sched
   import conv_arb_sched_pkg::*;
#(
   parameter int PIPE_LAT  = 2,
   parameter int BURST_LEN = 16
) (
   input  logic clk,
   input  logic resetn,
   conv_arb_sched_if.slave bus
`ifdef CONV_ARB_STATS_EN
   ,
   output logic [31:0] stat_beats0,
   output logic [31:0] stat_beats1,
   output logic [15:0] stat_frames0,
   output logic [15:0] stat_frames1
`endif
);

   localparam int CNT_W = $clog2(BURST_LEN);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_LEN - 1);

   state_t           state, state_next;
   logic             rr, rr_next;
   logic [CNT_W-1:0] burst_cnt, cnt_next;

   logic             gid;
   logic             cur_valid;
   logic             cur_last;
   logic             oth_valid;
   logic             burst_end;
   logic             beat;
   logic [PIX_W-1:0] sel_pix;
   tag_t             tag_in;
   tag_t             tag_out;

   // In IDLE these alias requester 0; beat is qualified by state below.
   assign gid       = (state == ST_GRANT1);
   assign cur_valid = gid ? bus.req1_valid : bus.req0_valid;
   assign cur_last  = gid ? bus.req1_last  : bus.req0_last;
   assign oth_valid = gid ? bus.req0_valid : bus.req1_valid;
   assign burst_end = cur_last || (burst_cnt == CNT_MAX);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= ST_IDLE;
         rr        <= 1'b0;
         burst_cnt <= '0;
      end else begin
         state     <= state_next;
         rr        <= rr_next;
         burst_cnt <= cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      rr_next    = rr;
      cnt_next   = burst_cnt;
      case (state)
         ST_IDLE: begin
            if (bus.req0_valid && bus.req1_valid) begin
               state_next = grant_state(rr);
            end else if (bus.req0_valid) begin
               state_next = ST_GRANT0;
            end else if (bus.req1_valid) begin
               state_next = ST_GRANT1;
            end
         end
         ST_GRANT0, ST_GRANT1: begin
            if (cur_valid) begin
               if (burst_end) begin
                  state_next = oth_valid ? grant_state(!gid) : ST_IDLE;
                  rr_next    = !gid;
                  cnt_next   = '0;
               end else begin
                  cnt_next = burst_cnt + 1'b1;
               end
            end else if (oth_valid) begin
               // Idle grantee hands over immediately instead of stalling the other side.
               state_next = grant_state(!gid);
               rr_next    = !gid;
               cnt_next   = '0;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.req0_ready = (state == ST_GRANT0);
      bus.req1_ready = (state == ST_GRANT1);
      beat           = (state != ST_IDLE) && cur_valid;
      sel_pix        = gid ? bus.req1_pix : bus.req0_pix;
      bus.kern_din_r = beat ? pix_ch(sel_pix, R_LSB) : '0;
      bus.kern_din_g = beat ? pix_ch(sel_pix, G_LSB) : '0;
      bus.kern_din_b = beat ? pix_ch(sel_pix, B_LSB) : '0;
      tag_in.beat    = beat;
      tag_in.id      = beat && gid;
      tag_in.last    = beat && cur_last;
   end

   conv_tag_pipe #(
      .DEPTH(PIPE_LAT)
   ) u_tag_pipe (
      .clk   (clk),
      .resetn(resetn),
      .din   (tag_in),
      .dout  (tag_out)
   );

   assign bus.res_valid = tag_out.beat;
   assign bus.res_id    = tag_out.id;
   assign bus.res_last  = tag_out.last;
   assign bus.res_data  = bus.kern_dout;

`ifdef CONV_ARB_STATS_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stat_beats0  <= '0;
         stat_beats1  <= '0;
         stat_frames0 <= '0;
         stat_frames1 <= '0;
      end else if (beat) begin
         if (gid) begin
            stat_beats1 <= stat_beats1 + 32'd1;
            if (cur_last) stat_frames1 <= stat_frames1 + 16'd1;
         end else begin
            stat_beats0 <= stat_beats0 + 32'd1;
            if (cur_last) stat_frames0 <= stat_frames0 + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_conv_arb_sched.sv
// Directed bench for conv_arb_sched with a 2-stage model kernel (R + 2G + 4B)
// and a result scoreboard; stats checks are compiled with CONV_ARB_STATS_EN.
module tb_conv_arb_sched;

   localparam int PIPE_LAT  = 2;
   localparam int BURST_LEN = 16;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   int   total  = 0;
   int   bad    = 0;

   always #5 clk = ~clk;

   conv_arb_sched_if bus ();

`ifdef CONV_ARB_STATS_EN
   logic [31:0] stat_beats0, stat_beats1;
   logic [15:0] stat_frames0, stat_frames1;
`endif

   conv_arb_sched #(
      .PIPE_LAT (PIPE_LAT),
      .BURST_LEN(BURST_LEN)
   ) dut (
      .clk   (clk),
      .resetn(resetn),
      .bus   (bus)
`ifdef CONV_ARB_STATS_EN
      ,
      .stat_beats0 (stat_beats0),
      .stat_beats1 (stat_beats1),
      .stat_frames0(stat_frames0),
      .stat_frames1(stat_frames1)
`endif
   );

   function automatic logic [17:0] kern_model(input logic [23:0] pix);
      return 18'(pix[23:16]) + 18'({pix[15:8], 1'b0}) + 18'({pix[7:0], 2'b00});
   endfunction

   logic [17:0] dp_s1, dp_s2;
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         dp_s1 <= '0;
         dp_s2 <= '0;
      end else begin
         dp_s1 <= kern_model({bus.kern_din_r, bus.kern_din_g, bus.kern_din_b});
         dp_s2 <= dp_s1;
      end
   end
   assign bus.kern_dout = dp_s2;

   logic [19:0] exp_q[$];
   int          acc_ids[$];
   int          acc_cyc[$];
   int          run_len[$];
   int          run_id[$];
   int          gaps;
   int          results;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.req0_valid = 1'b0;
      bus.req0_pix   = '0;
      bus.req0_last  = 1'b0;
      bus.req1_valid = 1'b0;
      bus.req1_pix   = '0;
      bus.req1_last  = 1'b0;
   endtask

   // Drives both producers, scoreboards every result and logs accepted beats.
   task automatic run_stream(input int n0, input int n1, input int f0, input int f1,
                             input logic [23:0] base0, input logic [23:0] base1,
                             input logic [23:0] step, input int budget);
      int          sent0, sent1, cyc;
      logic [19:0] e;
      logic [23:0] p;
      logic        lid;
      sent0 = 0; sent1 = 0; cyc = 0; gaps = 0; results = 0;
      acc_ids.delete();
      acc_cyc.delete();
      while ((sent0 < n0 || sent1 < n1 || exp_q.size() != 0) && cyc < budget) begin
         bus.req0_valid = (sent0 < n0);
         bus.req0_pix   = base0 + 24'(sent0) * step;
         bus.req0_last  = (sent0 < n0) && ((sent0 % f0) == f0 - 1);
         bus.req1_valid = (sent1 < n1);
         bus.req1_pix   = base1 + 24'(sent1) * step;
         bus.req1_last  = (sent1 < n1) && ((sent1 % f1) == f1 - 1);
         #1;
         if (bus.res_valid) begin
            results++;
            $display("res id=%0d last=%0d data=0x%0h", bus.res_id, bus.res_last, bus.res_data);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("res", {12'd0, bus.res_id, bus.res_last, bus.res_data}, {12'd0, e});
            end
         end
         if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready)) begin
            lid = bus.req1_ready;
            p   = lid ? bus.req1_pix : bus.req0_pix;
            check("kern_din", {8'd0, bus.kern_din_r, bus.kern_din_g, bus.kern_din_b}, {8'd0, p});
            exp_q.push_back({lid, lid ? bus.req1_last : bus.req0_last, kern_model(p)});
            acc_ids.push_back(int'(lid));
            acc_cyc.push_back(cyc);
            if (lid) sent1++; else sent0++;
         end else if (bus.req0_valid || bus.req1_valid) begin
            gaps++;
         end
         tick();
         cyc++;
      end
      clear_inputs();
      check("stream_in_budget", 32'(cyc < budget), 32'd1);
      check("res_count", results, n0 + n1);
      check("res_queue_empty", exp_q.size(), 0);
   endtask

   // Runs are maximal same-requester sequences of back-to-back accepted beats.
   task automatic build_runs();
      int tmp;
      run_len.delete();
      run_id.delete();
      for (int i = 0; i < acc_ids.size(); i++) begin
         if (i == 0 || acc_ids[i] != acc_ids[i-1] || acc_cyc[i] != acc_cyc[i-1] + 1) begin
            run_len.push_back(1);
            run_id.push_back(acc_ids[i]);
         end else begin
            tmp = run_len.pop_back();
            run_len.push_back(tmp + 1);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      clear_inputs();
      #12;
      check("rst_ready0", bus.req0_ready, 0);
      check("rst_ready1", bus.req1_ready, 0);
      check("rst_res_valid", bus.res_valid, 0);
      check("rst_kern_din", {bus.kern_din_r, bus.kern_din_g, bus.kern_din_b}, 0);
      tick();
      resetn = 1'b1;

      // Single white pixel: one result 2 cycles after acceptance.
      bus.req0_valid = 1'b1;
      bus.req0_pix   = 24'hFFFFFF;
      bus.req0_last  = 1'b1;
      #1;
      check("A_idle_ready0", bus.req0_ready, 0);
      tick();
      #1;
      check("A_grant_ready0", bus.req0_ready, 1);
      check("A_kern_din", {bus.kern_din_r, bus.kern_din_g, bus.kern_din_b}, 24'hFFFFFF);
      tick();
      clear_inputs();
      #1;
      check("A_after_ready0", bus.req0_ready, 0);
      check("A_bubble_din", {bus.kern_din_r, bus.kern_din_g, bus.kern_din_b}, 0);
      check("A_lat1_valid", bus.res_valid, 0);
      tick();
      #1;
      check("A_lat2_valid", bus.res_valid, 1);
      check("A_data", bus.res_data, 18'd1785);
      check("A_id", bus.res_id, 0);
      check("A_last", bus.res_last, 1);
      tick();
      #1;
      check("A_pulse_end", bus.res_valid, 0);
      tick();

      // req0 alone: 20 pixels split 16 + 4 with one re-entry cycle.
      run_stream(20, 0, 20, 1000, 24'h010203, 24'h0, 24'h0, 200);
      build_runs();
      check("B_nruns", run_len.size(), 2);
      check("B_run0", run_len[0], 16);
      check("B_run1", run_len[1], 4);
      check("B_gaps", gaps, 2);

      // Reset while two tags are in flight.
      bus.req0_valid = 1'b1;
      bus.req0_pix   = 24'h0A0B0C;
      tick();
      tick();
      tick();
      #1;
      check("R_inflight", bus.res_valid, 1);
      resetn = 1'b0;
      #1;
      check("R_res_valid", bus.res_valid, 0);
      check("R_ready0", bus.req0_ready, 0);
      check("R_kern_din", {bus.kern_din_r, bus.kern_din_g, bus.kern_din_b}, 0);
      check("R_res_id_last", {bus.res_id, bus.res_last}, 0);
      check("R_res_data", bus.res_data, 0);
      tick();
      check("R_next_valid", bus.res_valid, 0);
      clear_inputs();
      resetn = 1'b1;
      tick();

      // Both always valid: 0,1,0,1 bursts of 16, only the entry cycle idle.
      run_stream(32, 32, 1000, 1000, 24'h100000, 24'h200000, 24'h000101, 200);
      build_runs();
      check("C_nruns", run_len.size(), 4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("C_run%0d_len", i), run_len[i], 16);
         check($sformatf("C_run%0d_id", i), run_id[i], i % 2);
      end
      check("C_gaps", gaps, 1);

      // req0 stops after 5 beats while req1 waits: req1 gets a fresh 16-beat burst.
      run_stream(5, 20, 1000, 1000, 24'h300000, 24'h400000, 24'h000001, 200);
      build_runs();
      check("D_nruns", run_len.size(), 3);
      check("D_run0", run_len[0], 5);
      check("D_run0_id", run_id[0], 0);
      check("D_run1", run_len[1], 16);
      check("D_run1_id", run_id[1], 1);
      check("D_run2", run_len[2], 4);
      check("D_gaps", gaps, 3);

      // Three 5-pixel frames from req1 after a fresh reset.
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
`ifdef CONV_ARB_STATS_EN
      check("E_stat_rst", stat_beats1, 0);
`endif
      run_stream(0, 15, 1000, 5, 24'h0, 24'h050000, 24'h010101, 200);
      build_runs();
      check("E_nruns", run_len.size(), 3);
      check("E_run0", run_len[0], 5);
      check("E_run2", run_len[2], 5);
      check("E_gaps", gaps, 3);
`ifdef CONV_ARB_STATS_EN
      check("E_beats1", stat_beats1, 15);
      check("E_frames1", stat_frames1, 3);
      check("E_beats0", stat_beats0, 0);
      check("E_frames0", stat_frames0, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/conv_arb_sched.md
CONV_ARB_SCHED -- requirements
Module: conv_arb_sched

Interface
REQ-001 Parameter PIPE_LAT, default 2: fixed latency in clk cycles from kern_din_* to the matching kern_dout; legal range 1..8.
REQ-002 Parameter BURST_LEN, default 16: maximum pixels accepted per grant before re-arbitration; legal range 2..256.
REQ-003 clk  input  1  clock; all logic on its rising edge.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 reqN_valid  input  1  (N=0,1) pixel offered by requester N.
REQ-006 reqN_pix  input  24  (N=0,1) pixel {R[23:16],G[15:8],B[7:0]}, unsigned.
REQ-007 reqN_last  input  1  (N=0,1) marks the last pixel of a frame.
REQ-008 reqN_ready  output  1  (N=0,1) requester N is granted; a beat transfers when valid&&ready.
REQ-009 kern_din_r/g/b  output  8 each  pixel channels to the shared 1x1x3 kernel datapath.
REQ-010 kern_dout  input  18  datapath result, valid PIPE_LAT cycles after kern_din_*.
REQ-011 res_valid  output  1  res_data holds a real result.
REQ-012 res_data  output  18  result forwarded from kern_dout.
REQ-013 res_id  output  1  requester that issued the result.
REQ-014 res_last  output  1  result belongs to the last pixel of a frame.

Function
REQ-015 FSM states: IDLE, GRANT0, GRANT1; reqN_ready SHALL be 1 only in GRANTN and SHALL be a pure function of registered state.
REQ-016 IDLE: next state is GRANT of the valid requester; if both are valid, the requester selected by the round-robin pointer rr; if neither, stay IDLE.
REQ-017 GRANTN: each accepted beat increments burst_cnt; burst ends on an accepted beat with reqN_last=1 or burst_cnt=BURST_LEN-1.
REQ-018 At burst end: go to GRANT(other) if req(other)_valid is 1 in the same cycle, else IDLE; rr points to the other requester; burst_cnt clears.
REQ-019 GRANTN with reqN_valid=0: switch to GRANT(other) if req(other)_valid=1, with rr updated and burst_cnt cleared; else hold GRANTN.
REQ-020 kern_din_* SHALL carry the granted pixel on accepted beats and 0 on all other cycles (bubble).
REQ-021 A tag shift register of depth PIPE_LAT SHALL carry {beat_accepted, id, last} alongside the datapath.
REQ-022 res_valid/res_id/res_last SHALL equal the tag emerging after PIPE_LAT cycles; res_data = kern_dout, passed combinationally; there is no output backpressure.
REQ-023 Back-to-back accepted beats SHALL sustain 1 pixel/cycle within a burst; a switch between requesters SHALL cost 0 bubbles; entry from IDLE costs 1 cycle.
REQ-024 Results SHALL exit in acceptance order; no result is dropped or duplicated.

Reset
REQ-025 On resetn low: state IDLE, rr=0, burst_cnt=0, all tag stages cleared, all outputs 0, regardless of in-flight beats.
REQ-026 On resetn deassertion, the first arbitration SHALL favour requester 0 when both are valid.

Configuration
REQ-027 With CONV_ARB_STATS_EN defined: extra outputs stat_beats0, stat_beats1 (32-bit, wrapping accepted-beat counts) and stat_frames0, stat_frames1 (16-bit, wrapping counts of accepted last beats), all reset to 0.
REQ-028 Without CONV_ARB_STATS_EN: these ports and counters do not exist; all other behaviour is identical.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding, the tag field layout and pixel field positions.
REQ-030 Sub-module conv_tag_pipe (parameterised delay line for the tag) SHALL be used; arbitration stays in the top.

Verification
REQ-031 Reset mid-burst with 2 tags in flight -> res_valid=0 on the next cycle, all outputs 0, state IDLE.
REQ-032 Only req0 streams 20 pixels 0x010203, last on pixel 20, BURST_LEN=16 -> bursts of 16 and 4; 20 results in order, 1-cycle gap at re-entry.
REQ-033 Both requesters continuously valid -> grants alternate 0,1,0 in 16-beat bursts with zero idle cycles; res_id follows the same order.
REQ-034 Pixel R=G=B=0xFF with a model datapath (PIPE_LAT=2) -> res_data equals the model output exactly 2 cycles after acceptance, res_valid pulses once.
REQ-035 req0 drops valid mid-burst while req1 is valid -> grant moves to req1 on the next cycle; burst_cnt restarts at 0.
REQ-036 CONV_ARB_STATS_EN build: 3 frames of 5 pixels from req1 -> stat_beats1=15, stat_frames1=3, stat_beats0=0.
